// File: rtl/tick_sched.sv
// tick_sched: multi-channel periodic tick-strobe scheduler with shadowed, boundary-applied periods.
// Define TICK_SCHED_LVL_EN to build the per-channel lvl square waves; otherwise lvl is tied to 0.
module tick_sched #(
    parameter int          N_CH        = 4,
    parameter int          CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  lvl,
    output logic [N_CH-1:0]  cfg_pend
);

    // DEFAULT_DIV is truncated to CNT_W bits: a true 1 Hz tick at 50 MHz needs CNT_W >= 26.
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] cnt;
        logic             pend;
        logic             tick_q;
        logic             wr;
        logic             active;
        logic             at_end;

        // Out-of-range channel indices never match, so those writes fall away here.
        assign wr     = cfg_we && (cfg_ch == 3'(i));
        assign active = en[i] && (div_q != '0);
        assign at_end = active && (cnt == div_q - ONE);

        always_ff @(posedge clk_in) begin
            if (rst) begin
                div_q  <= RST_DIV;
                shadow <= RST_DIV;
                pend   <= 1'b0;
                cnt    <= '0;
                tick_q <= 1'b0;
            end else if (sync) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                pend   <= 1'b0;
                if (wr) begin
                    div_q  <= cfg_div;
                    shadow <= cfg_div;
                end else if (pend) begin
                    div_q <= shadow;
                end
            end else if (!active) begin
                // Disabled or idle channel: a write takes effect immediately.
                cnt    <= '0;
                tick_q <= 1'b0;
                if (wr) begin
                    div_q  <= cfg_div;
                    shadow <= cfg_div;
                    pend   <= 1'b0;
                end
            end else begin
                tick_q <= at_end;
                if (at_end) begin
                    cnt <= '0;
                    if (pend) begin
                        div_q <= shadow;
                        pend  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
                // NOTE: later non-blocking assignments win, so a write on a boundary re-arms pend.
                if (wr) begin
                    shadow <= cfg_div;
                    pend   <= 1'b1;
                end
            end
        end

        assign tick[i]     = tick_q;
        assign cfg_pend[i] = pend;

`ifdef TICK_SCHED_LVL_EN
        logic lvl_q;

        always_ff @(posedge clk_in) begin
            if (rst || sync || !en[i]) begin
                lvl_q <= 1'b0;
            end else if (at_end) begin
                lvl_q <= ~lvl_q;
            end
        end

        assign lvl[i] = lvl_q;
`else
        assign lvl[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: a per-edge vector table plus hand-written multi-cycle sequences.
module tb_tick_sched;

    localparam int CNT_W = 25;

`ifdef TICK_SCHED_LVL_EN
    localparam logic [3:0] LVL_MASK = 4'hF;
`else
    localparam logic [3:0] LVL_MASK = 4'h0;
`endif

    logic             clk_in = 1'b0;
    logic             rst;
    logic [3:0]       en;
    logic             sync;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [3:0]       tick;
    logic [3:0]       lvl;
    logic [3:0]       cfg_pend;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             rst;
        logic [3:0]       en;
        logic             sync;
        logic             we;
        logic [2:0]       ch;
        logic [CNT_W-1:0] div;
        logic [3:0]       tick;
        logic [3:0]       lvl;
        logic [3:0]       pend;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_t;
    logic [3:0] exp_l;
    int         per[4] = '{3, 5, 6, 4};

    tick_sched #(
        .N_CH       (4),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(5)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .tick    (tick),
        .lvl     (lvl),
        .cfg_pend(cfg_pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic s, input logic w,
                         input logic [2:0] c, input logic [CNT_W-1:0] d);
        rst     = r;
        en      = e;
        sync    = s;
        cfg_we  = w;
        cfg_ch  = c;
        cfg_div = d;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic s, input logic w,
                                input logic [2:0] c, input logic [CNT_W-1:0] d,
                                input logic [3:0] t, input logic [3:0] l, input logic [3:0] p);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.sync = s;
        v.we   = w;
        v.ch   = c;
        v.div  = d;
        v.tick = t;
        v.lvl  = l;
        v.pend = p;
        return v;
    endfunction

    initial begin
        drive(1'b1, 4'hF, 1'b0, 1'b0, 3'd0, '0);

        // Reset, period 5 on all channels, then div 3 written to ch0 at cnt=1; invalid ch5 write.
        tbl.push_back(mk(1, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // reset edge
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e0
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e1
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e2
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e3
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0));  // e4
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0));  // e5
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0));  // e6
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0));  // e7
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0));  // e8
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0));  // e9
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e10
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e11
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e12
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e13
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0));  // e14
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h0));  // e15
        tbl.push_back(mk(0, 4'hF, 0, 1, 0, 3, 4'h0, 4'hF, 4'h1));  // e16 write ch0 div 3
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h1));  // e17
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'hF, 4'h1));  // e18
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0));  // e19 boundary applies 3
        tbl.push_back(mk(0, 4'hF, 0, 1, 5, 2, 4'h0, 4'h0, 4'h0));  // e20 ch5 ignored
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));  // e21
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0));  // e22
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0));  // e23
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'hE, 4'hF, 4'h0));  // e24
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h1, 4'hE, 4'h0));  // e25

        foreach (tbl[r]) begin
            drive(tbl[r].rst, tbl[r].en, tbl[r].sync, tbl[r].we, tbl[r].ch, tbl[r].div);
            step();
            check($sformatf("tbl%0d_tick", r), tick, tbl[r].tick);
            check($sformatf("tbl%0d_lvl", r), lvl, tbl[r].lvl & LVL_MASK);
            check($sformatf("tbl%0d_pend", r), cfg_pend, tbl[r].pend);
        end

        // Disable ch2, write period 7 while disabled, then enable: ticks at E0+6 and E0+13.
        drive(0, 4'b1011, 0, 0, 0, '0);
        step();
        check("dis_tick2", tick[2], 1'b0);
        check("dis_lvl2", lvl[2], 1'b0);
        drive(0, 4'b1011, 0, 1, 2, 7);
        step();
        check("dis_wr_pend2", cfg_pend[2], 1'b0);
        drive(0, 4'hF, 0, 0, 0, '0);
        for (int k = 0; k <= 13; k++) begin
            step();
            check($sformatf("en2_k%0d_tick", k), tick[2], (k == 6 || k == 13));
            if (k == 0) check("en2_pend2", cfg_pend[2], 1'b0);
        end

        // Pending write on ch3, then sync with a simultaneous write to ch2: periods {3,5,6,4}.
        drive(0, 4'hF, 0, 1, 3, 4);
        step();
        check("pre_sync_pend", cfg_pend, 4'b1000);
        drive(0, 4'hF, 1, 1, 2, 6);
        step();
        check("sync_tick", tick, 4'h0);
        check("sync_lvl", lvl, 4'h0);
        check("sync_pend", cfg_pend, 4'h0);
        drive(0, 4'hF, 0, 0, 0, '0);
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                exp_t[i] = (k % per[i]) == 0;
                exp_l[i] = ((k / per[i]) % 2) == 1;
            end
            check($sformatf("resync_k%0d_tick", k), tick, exp_t);
            check($sformatf("resync_k%0d_lvl", k), lvl, exp_l & LVL_MASK);
        end

        // Realign again, then two writes to ch1 before its boundary: the last one (2) wins.
        drive(0, 4'hF, 1, 0, 0, '0);
        step();
        check("sync2_tick", tick, 4'h0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 1)      drive(0, 4'hF, 0, 1, 1, 9);
            else if (k == 2) drive(0, 4'hF, 0, 1, 1, 2);
            else             drive(0, 4'hF, 0, 0, 0, '0);
            step();
            check($sformatf("lww_k%0d_tick1", k), tick[1], (k == 5 || k == 7 || k == 9 || k == 11));
            check($sformatf("lww_k%0d_pend1", k), cfg_pend[1], (k <= 4));
        end

        // ch0 period 1 (constant tick, lvl toggles every cycle), then period 0 (idle, lvl holds).
        drive(0, 4'b1110, 0, 0, 0, '0);
        step();
        check("div1_dis_tick0", tick[0], 1'b0);
        drive(0, 4'b1110, 0, 1, 0, 1);
        step();
        check("div1_wr_pend0", cfg_pend[0], 1'b0);
        for (int k = 0; k <= 10; k++) begin
            drive(0, 4'hF, 0, (k == 5), 0, '0);
            step();
            check($sformatf("div01_k%0d_tick0", k), tick[0], (k <= 6));
            check($sformatf("div01_k%0d_lvl0", k), lvl[0],
                  LVL_MASK[0] & ((k <= 6) ? (k % 2 == 0) : 1'b1));
            check($sformatf("div01_k%0d_pend0", k), cfg_pend[0], (k == 5));
        end

        // Reset with a write pending and counters mid-count; a write during reset is ignored.
        drive(0, 4'hF, 0, 1, 1, 8);
        step();
        check("pre_rst_pend1", cfg_pend[1], 1'b1);
        drive(1, 4'hF, 0, 1, 0, 2);
        step();
        check("rst_tick", tick, 4'h0);
        check("rst_lvl", lvl, 4'h0);
        check("rst_pend", cfg_pend, 4'h0);
        drive(0, 4'hF, 0, 0, 0, '0);
        for (int r = 0; r <= 4; r++) begin
            step();
            check($sformatf("post_rst_e%0d_tick", r), tick, (r == 4) ? 4'hF : 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
